mul3_seq_ctrl: RTL

//  Sequential controller for the three-operand product P2 = (a*b)*c.

---
 rtl/mul3_seq_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mul3_seq_ctrl.sv
// Two-pass shift-add controller computing p1=a*b then p2=p1*c on one accumulator.
// Optional MUL3_ZERO_SKIP_EN: short-circuits passes when an operand is zero.
module mul3_seq_ctrl #(
    parameter int  AW  = 4,
    parameter int  BW  = 4,
    parameter int  CW  = 8,
    localparam int P1W = AW + BW,
    localparam int P2W = P1W + CW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [AW-1:0]  a,
    input  logic [BW-1:0]  b,
    input  logic [CW-1:0]  c,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [P1W-1:0] p1,
    output logic [P2W-1:0] p2,
    output logic           busy
);

    localparam int MAXN = (BW > CW) ? BW : CW;
    localparam int CNTW = (MAXN > 1) ? $clog2(MAXN) : 1;
    localparam logic [CNTW-1:0] LAST1 = CNTW'(BW - 1);
    localparam logic [CNTW-1:0] LAST2 = CNTW'(CW - 1);

    typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

    state_t          state_q;
    logic [CNTW-1:0] cnt_q;
    logic [AW-1:0]   a_q;
    logic [BW-1:0]   b_q;
    logic [CW-1:0]   c_q;
    logic [P1W-1:0]  acc1_q;
    logic [P2W-1:0]  acc2_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            busy_q;

    logic [BW-1:0]   b_sh;
    logic [CW-1:0]   c_sh;
    logic [P1W-1:0]  add1_d;
    logic [P2W-1:0]  add2_d;

    // Shift the multiplier right instead of indexing it, so the counter width
    // never has to match the operand index width.
    assign b_sh   = b_q >> cnt_q;
    assign c_sh   = c_q >> cnt_q;
    assign add1_d = b_sh[0] ? (P1W'(a_q) << cnt_q) : '0;
    assign add2_d = c_sh[0] ? (P2W'(acc1_q) << cnt_q) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            acc1_q      <= '0;
            acc2_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        c_q        <= c;
                        acc1_q     <= '0;
                        acc2_q     <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
`ifdef MUL3_ZERO_SKIP_EN
                        if (a == '0 || b == '0) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= PASS1;
                            busy_q  <= 1'b1;
                        end
`else
                        state_q <= PASS1;
                        busy_q  <= 1'b1;
`endif
                    end
                end
                PASS1: begin
                    acc1_q <= acc1_q + add1_d;
                    if (cnt_q == LAST1) begin
                        cnt_q <= '0;
`ifdef MUL3_ZERO_SKIP_EN
                        if (c_q == '0) begin
                            state_q     <= DONE;
                            busy_q      <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= PASS2;
                        end
`else
                        state_q <= PASS2;
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                PASS2: begin
                    acc2_q <= acc2_q + add2_d;
                    if (cnt_q == LAST2) begin
                        cnt_q       <= '0;
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Accumulators are only written outside DONE, so they double as result regs.
    assign p1        = acc1_q;
    assign p2        = acc2_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule
